// File: rtl/dram_bist_pkg.sv
// Shared types and constants for the DRAM BIST traffic generator/checker.
// Imported by the pattern generator and the top-level FSM.
package dram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        CHECK,
        DONE
    } bist_state_t;

    localparam logic [1:0] PAT_ADDR     = 2'd0;
    localparam logic [1:0] PAT_A5       = 2'd1;
    localparam logic [1:0] PAT_CHECKER  = 2'd2;
    localparam logic [1:0] PAT_INV_ADDR = 2'd3;

    localparam int ADDR_BYTE_SHIFT = 7;

endpackage

// File: rtl/dram_bist_pattern.sv
// Combinational test-pattern generator: one 32-bit lane per (sel, idx),
// replicated across the data word. Shared by the write and check paths.
module dram_bist_pattern
    import dram_bist_pkg::*;
#(
    parameter int WORD_SIZE  = 256,
    parameter int ADDR_WIDTH = 25
) (
    input  logic [1:0]            sel_i,
    input  logic [ADDR_WIDTH-1:0] idx_i,
    output logic [WORD_SIZE-1:0]  word_o
);

    logic [31:0] idx_ext;
    logic [31:0] lane;

    assign idx_ext = 32'(idx_i);

    always_comb begin
        lane = idx_ext;
        unique case (sel_i)
            PAT_ADDR:     lane = idx_ext;
            PAT_A5:       lane = 32'hA5A5_A5A5;
            PAT_CHECKER:  lane = idx_i[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            PAT_INV_ADDR: lane = ~idx_ext;
            default:      lane = idx_ext;
        endcase
    end

    assign word_o = {(WORD_SIZE / 32){lane}};

endmodule

// File: rtl/dram_bist.sv
// Wishbone BIST master: writes a pattern over NUM_WORDS words, reads them
// back and reports pass/fail, error count, first bad index and timeout.
module dram_bist
    import dram_bist_pkg::*;
#(
    parameter int WORD_SIZE      = 256,
    parameter int ADDR_WIDTH     = 25,
    parameter int NUM_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  initialized_i,
    input  logic                  start_i,
    input  logic [1:0]            pattern_sel_i,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [31:0]           addr_o,
    output logic [WORD_SIZE-1:0]  data_o,
    input  logic [WORD_SIZE-1:0]  data_i,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timeout_o,
    output logic [15:0]           error_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_idx_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [ADDR_BYTE_SHIFT-1:0] BYTE_ZERO = '0;

    bist_state_t state_q, state_d;

    logic [1:0]            sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [31:0]           addr_q, addr_d;
    logic [WORD_SIZE-1:0]  data_q, data_d;
    logic [WORD_SIZE-1:0]  cap_q, cap_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  tout_q, tout_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;

    logic [ADDR_WIDTH-1:0] idx_inc;
    logic [ADDR_WIDTH-1:0] pat_idx;
    logic [WORD_SIZE-1:0]  pat_word;
    logic                  ack_ok;
    logic                  tmo_hit;
    logic                  mismatch;

    assign idx_inc  = idx_q + ADDR_WIDTH'(1);
    // WR_GAP prepares the next write, so the generator looks one word ahead.
    assign pat_idx  = (state_q == WR_GAP) ? idx_inc : idx_q;
    assign ack_ok   = ack_i & stb_q;
    assign tmo_hit  = stb_q & ~ack_i & (tmo_q == TMO_LAST);
    assign mismatch = (cap_q != pat_word);

    dram_bist_pattern #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pattern (
        .sel_i  (sel_q),
        .idx_i  (pat_idx),
        .word_o (pat_word)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cap_d   = cap_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tout_d  = tout_q;
        err_d   = err_q;
        first_d = first_q;
        tmo_d   = (stb_q && !ack_i) ? tmo_q + TW'(1) : tmo_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = WAIT_INIT;
                    sel_d   = pattern_sel_i;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tout_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            WAIT_INIT: begin
                if (initialized_i) begin
                    state_d = WR_REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {idx_q, BYTE_ZERO};
                    data_d  = pat_word;
                    tmo_d   = '0;
                end
            end
            WR_REQ: begin
                if (ack_ok) begin
                    state_d = WR_GAP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            WR_GAP: begin
                cyc_d = 1'b1;
                stb_d = 1'b1;
                tmo_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = RD_REQ;
                    idx_d   = '0;
                    we_d    = 1'b0;
                end else begin
                    state_d = WR_REQ;
                    idx_d   = idx_inc;
                    we_d    = 1'b1;
                    data_d  = pat_word;
                end
                addr_d = {idx_d, BYTE_ZERO};
            end
            RD_REQ: begin
                if (ack_ok) begin
                    state_d = CHECK;
                    cap_d   = data_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q == '0) first_d = idx_q;
                    if (err_q != '1) err_d = err_q + 16'd1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    fail_d  = (err_d != '0);
                end else begin
                    state_d = RD_REQ;
                    idx_d   = idx_inc;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    addr_d  = {idx_inc, BYTE_ZERO};
                    tmo_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled slave aborts the run regardless of phase.
        if (tmo_hit) begin
            state_d = DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            fail_d  = 1'b1;
            tout_d  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tout_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign cyc_o           = cyc_q;
    assign stb_o           = stb_q;
    assign we_o            = we_q;
    assign addr_o          = addr_q;
    assign data_o          = data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign fail_o          = fail_q;
    assign timeout_o       = tout_q;
    assign error_count_o   = err_q;
    assign first_err_idx_o = first_q;

endmodule

// File: tb/tb_dram_bist.sv
// Bench for dram_bist: behavioural Wishbone memory, table-driven and random
// runs against a pattern/outcome model, plus timeout, init and reset cases.
module tb_dram_bist;

    localparam int WS = 256;
    localparam int AW = 25;
    localparam int NW = 16;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          initialized_i = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    pattern_sel_i = 2'd0;
    logic          cyc_o, stb_o, we_o;
    logic [31:0]   addr_o;
    logic [WS-1:0] data_o;
    logic [WS-1:0] data_i;
    logic          ack_i;
    logic          busy_o, done_o, pass_o, fail_o, timeout_o;
    logic [15:0]   error_count_o;
    logic [AW-1:0] first_err_idx_o;

    dram_bist #(
        .WORD_SIZE      (WS),
        .ADDR_WIDTH     (AW),
        .NUM_WORDS      (NW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk         (clk),
        .rst             (rst),
        .initialized_i   (initialized_i),
        .start_i         (start_i),
        .pattern_sel_i   (pattern_sel_i),
        .cyc_o           (cyc_o),
        .stb_o           (stb_o),
        .we_o            (we_o),
        .addr_o          (addr_o),
        .data_o          (data_o),
        .data_i          (data_i),
        .ack_i           (ack_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .fail_o          (fail_o),
        .timeout_o       (timeout_o),
        .error_count_o   (error_count_o),
        .first_err_idx_o (first_err_idx_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [WS-1:0] act,
                         input logic [WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference pattern straight from the pattern rules.
    function automatic logic [WS-1:0] exp_word(input logic [1:0] sel, input int idx);
        logic [31:0] w;
        case (sel)
            2'd0:    w = 32'(idx);
            2'd1:    w = 32'hA5A5A5A5;
            2'd2:    w = (idx % 2 == 0) ? 32'h55555555 : 32'hAAAAAAAA;
            default: w = ~32'(idx);
        endcase
        return {(WS / 32){w}};
    endfunction

    // Memory model state and fault injection
    logic [WS-1:0] mem [NW];
    logic [31:0]   wr_addr_q [$];
    logic [WS-1:0] wr_data_q [$];
    int            rd_cnt = 0;
    bit            resp_en = 1'b1;
    bit            manual_ack = 1'b0;
    bit            cur_zero = 1'b0;
    logic [15:0]   cur_flip = '0;
    int            cur_bit = 0;
    int            cur_lat = 3;
    int            cnt = 0;
    logic [3:0]    widx;

    function automatic logic [WS-1:0] flip_mask(input logic [15:0] flip,
                                                 input int i, input int b);
        return flip[i] ? (WS'(1) << b) : '0;
    endfunction

    initial begin
        ack_i  = 1'b0;
        data_i = '0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                cnt   = 0;
                ack_i = manual_ack;
                if (manual_ack) data_i = {(WS / 32){32'hDEADBEEF}};
            end else if (ack_i) begin
                ack_i = 1'b0;
                cnt   = 0;
            end else if (cyc_o && stb_o) begin
                cnt++;
                if (cnt >= cur_lat) begin
                    ack_i = 1'b1;
                    widx  = addr_o[10:7];
                    if (we_o) begin
                        mem[widx] = data_o;
                        wr_addr_q.push_back(addr_o);
                        wr_data_q.push_back(data_o);
                    end else begin
                        data_i = cur_zero ? '0
                               : mem[widx] ^ flip_mask(cur_flip, int'(widx), cur_bit);
                        rd_cnt++;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    typedef struct {
        logic [1:0]  sel;
        bit          zero;
        logic [15:0] flip;
        int          bit_pos;
        int          lat;
        int          exp_err;
        int          exp_first;
        bit          exp_pass;
    } vec_t;

    vec_t vecs [$];

    // Outcome model: what the memory hands back versus the reference pattern.
    function automatic vec_t make_random_vec();
        vec_t v;
        logic [WS-1:0] rv;
        v.sel       = 2'($urandom_range(0, 3));
        v.zero      = ($urandom_range(0, 5) == 0);
        v.flip      = 16'($urandom) & 16'($urandom);
        v.bit_pos   = $urandom_range(0, WS - 1);
        v.lat       = $urandom_range(1, 5);
        v.exp_err   = 0;
        v.exp_first = 0;
        for (int i = 0; i < NW; i++) begin
            rv = v.zero ? '0 : exp_word(v.sel, i) ^ flip_mask(v.flip, i, v.bit_pos);
            if (rv != exp_word(v.sel, i)) begin
                if (v.exp_err == 0) v.exp_first = i;
                v.exp_err++;
            end
        end
        v.exp_pass = (v.exp_err == 0);
        return v;
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_cnt = 0;
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        pattern_sel_i = sel;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input logic [1:0] sel, output bit ok);
        clear_log();
        pulse_start(sel);
        wait_done(ok);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {cyc_o, stb_o, we_o, busy_o, done_o, pass_o,
                              fail_o, timeout_o}, '0);
        check({tag, "_err"}, error_count_o, '0);
        check({tag, "_first"}, first_err_idx_o, '0);
        check({tag, "_addr"}, addr_o, '0);
        check({tag, "_data"}, data_o, '0);
    endtask

    int unsigned bad;
    int  n;
    bit  ok;
    bit  saw_cyc;
    bit  lost_busy;
    bit  found;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{2'd0, 1'b0, 16'h0000, 0,   3, 0,  0, 1'b1});
        vecs.push_back('{2'd1, 1'b0, 16'h0200, 0,   3, 1,  9, 1'b0});
        vecs.push_back('{2'd2, 1'b1, 16'h0000, 0,   3, 16, 0, 1'b0});
        vecs.push_back('{2'd3, 1'b0, 16'h8008, 255, 2, 2,  3, 1'b0});
        for (int r = 0; r < 6; r++) vecs.push_back(make_random_vec());

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("idle");
        initialized_i = 1'b1;

        foreach (vecs[k]) begin
            cur_zero = vecs[k].zero;
            cur_flip = vecs[k].flip;
            cur_bit  = vecs[k].bit_pos;
            cur_lat  = vecs[k].lat;
            run(vecs[k].sel, ok);
            check($sformatf("v%0d_done_wait", k), ok, 1);
            check($sformatf("v%0d_pass", k), pass_o, vecs[k].exp_pass);
            check($sformatf("v%0d_fail", k), fail_o, !vecs[k].exp_pass);
            check($sformatf("v%0d_timeout", k), timeout_o, 0);
            check($sformatf("v%0d_busy", k), busy_o, 0);
            check($sformatf("v%0d_err", k), error_count_o, vecs[k].exp_err);
            check($sformatf("v%0d_first", k), first_err_idx_o, vecs[k].exp_first);
            bad = (wr_addr_q.size() == NW) ? 0 : 1;
            for (int i = 0; i < wr_addr_q.size(); i++)
                if (wr_addr_q[i] !== 32'(i << 7) ||
                    wr_data_q[i] !== exp_word(vecs[k].sel, i)) bad++;
            check($sformatf("v%0d_wr_seq", k), bad, 0);
            check($sformatf("v%0d_rd_cnt", k), rd_cnt, NW);
            if (k == 0) begin
                check("v0_word5", wr_data_q[5], {8{32'h5}});
                check("v0_addr15", wr_addr_q[15], 32'h780);
            end
        end

        // Slave never acknowledges: abort after TO cycles of strobe.
        resp_en = 1'b0;
        cur_flip = '0;
        cur_zero = 1'b0;
        cur_lat = 3;
        clear_log();
        pulse_start(2'd0);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (stb_o) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("tmo_stb_rise", found, 1);
        n = 0;
        while (stb_o && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_len", n, TO);
        check("tmo_cyc", cyc_o, 0);
        check("tmo_flags", {done_o, timeout_o, fail_o, pass_o, busy_o}, 5'b11100);
        resp_en = 1'b1;

        // Calibration held off: no bus traffic, restarts ignored.
        initialized_i = 1'b0;
        clear_log();
        pulse_start(2'd2);
        saw_cyc = 1'b0;
        lost_busy = 1'b0;
        for (int c = 0; c < 50; c++) begin
            start_i = (c == 10 || c == 30);
            @(posedge clk); #1;
            if (cyc_o) saw_cyc = 1'b1;
            if (!busy_o) lost_busy = 1'b1;
        end
        start_i = 1'b0;
        check("init_no_cyc", saw_cyc, 0);
        check("init_busy", lost_busy, 0);
        initialized_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("init_busy_mid", busy_o, 1);
        wait_done(ok);
        check("init_done_wait", ok, 1);
        check("init_wr_cnt", wr_addr_q.size(), NW);
        check("init_rd_cnt", rd_cnt, NW);
        check("init_pass", pass_o, 1);

        // Reset while the fifth read is outstanding.
        cur_flip = 16'h0004;
        cur_bit = 7;
        clear_log();
        pulse_start(2'd1);
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (cyc_o && stb_o && !we_o && addr_o == 32'h200) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst_reach_rd4", found, 1);
        check("rst_pre_err", error_count_o, 1);
        resp_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midrst");
        rst = 1'b0;
        manual_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        manual_ack = 1'b0;
        @(posedge clk); #1;
        check("late_ack_idle", {cyc_o, stb_o, busy_o, done_o, error_count_o}, '0);
        resp_en = 1'b1;
        cur_flip = '0;
        run(2'd1, ok);
        check("post_rst_done", ok, 1);
        check("post_rst_pass", {pass_o, fail_o}, 2'b10);
        check("post_rst_err", error_count_o, 0);
        check("post_rst_wr", wr_addr_q.size(), NW);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
